// File: rtl/mc10_vram_arbiter.sv
// VRAM arbiter for the MC10: shares one synchronous BRAM between MC6847 fetches
// and CPU accesses, and holds the VDG mode control latch (css/an_g/gm).
// VDG fetches have priority; a fetch arriving mid-CPU-access is parked and issued at next IDLE.
module mc10_vram_arbiter #(
  parameter logic [15:0] RAM_BASE  = 16'h4000,
  parameter int          RAM_AW    = 13,
  parameter logic [15:0] CTRL_ADDR = 16'hBFFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              vdg_req,
  input  logic [12:0]       vdg_addr,
  output logic [7:0]        vdg_dd,
  output logic              vdg_late,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              an_g,
  output logic [2:0]        gm,
  output logic              css
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VADDR = 3'd1,
    VCAP  = 3'd2,
    CADDR = 3'd3,
    CCAP  = 3'd4,
    CWR   = 3'd5
  } state_t;

  // Number of bytes in the RAM window, one bit wider than the CPU address so
  // a window reaching the top of the address map still compares correctly.
  localparam logic [16:0] RAM_SPAN = 17'd1 << RAM_AW;

  state_t            state, state_n;
  logic              pend, pend_n;
  logic [RAM_AW-1:0] pend_addr, pend_addr_n;

  logic [7:0]        vdg_dd_n;
  logic              vdg_late_n;
  logic [7:0]        cpu_rdata_n;
  logic              cpu_ack_n;
  logic [RAM_AW-1:0] ram_addr_n;
  logic              ram_we_n;
  logic [7:0]        ram_din_n;
  logic              an_g_n;
  logic [2:0]        gm_n;
  logic              css_n;

  logic [RAM_AW-1:0] vdg_fetch;
  logic [15:0]       cpu_off;
  logic              cpu_in_ram;
  logic              cpu_is_ctrl;
  logic              cpu_start;

  // Address decode for the VDG and CPU sides
  always_comb begin
    vdg_fetch   = RAM_AW'(vdg_addr);
    cpu_off     = cpu_addr - RAM_BASE;
    cpu_in_ram  = ({1'b0, cpu_off} < RAM_SPAN);
    cpu_is_ctrl = (cpu_addr == CTRL_ADDR);
    // cpu_req is still high during the ack cycle; that is the tail of the
    // finished access, not a new one.
    cpu_start   = cpu_req && !cpu_ack;
  end

  // Next-state and next-register logic for the arbiter FSM
  always_comb begin
    state_n     = state;
    pend_n      = pend;
    pend_addr_n = pend_addr;
    vdg_dd_n    = vdg_dd;
    vdg_late_n  = 1'b0;
    cpu_rdata_n = cpu_rdata;
    cpu_ack_n   = 1'b0;
    ram_addr_n  = ram_addr;
    ram_we_n    = 1'b0;
    ram_din_n   = ram_din;
    an_g_n      = an_g;
    gm_n        = gm;
    css_n       = css;

    // Outside IDLE a fetch is parked; a second one before issue replaces it.
    if (vdg_req && (state != IDLE)) begin
      pend_n      = 1'b1;
      pend_addr_n = vdg_fetch;
      vdg_late_n  = pend;
    end

    case (state)
      IDLE: begin
        if (pend || vdg_req) begin
          // A fresh request this cycle supersedes any parked address.
          ram_addr_n = vdg_req ? vdg_fetch : pend_addr;
          pend_n     = 1'b0;
          vdg_late_n = pend && vdg_req;
          state_n    = VADDR;
        end else if (cpu_start && cpu_in_ram) begin
          ram_addr_n = RAM_AW'(cpu_off);
          if (cpu_we) begin
            ram_we_n  = 1'b1;
            ram_din_n = cpu_wdata;
            state_n   = CWR;
          end else begin
            state_n   = CADDR;
          end
        end else if (cpu_start && cpu_is_ctrl) begin
          if (cpu_we) begin
            css_n  = cpu_wdata[6];
            an_g_n = cpu_wdata[5];
            gm_n   = cpu_wdata[4:2];
          end else begin
            cpu_rdata_n = {1'b0, css, an_g, gm, 2'b00};
          end
          cpu_ack_n = 1'b1;
        end else if (cpu_start) begin
          // Unmapped: reads float high, writes are dropped.
          cpu_rdata_n = 8'hFF;
          cpu_ack_n   = 1'b1;
        end
      end
      VADDR: state_n = VCAP;
      VCAP: begin
        vdg_dd_n = ram_dout;
        state_n  = IDLE;
      end
      CADDR: state_n = CCAP;
      CCAP: begin
        cpu_rdata_n = ram_dout;
        cpu_ack_n   = 1'b1;
        state_n     = IDLE;
      end
      CWR: begin
        cpu_ack_n = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      pend_addr <= '0;
      vdg_dd    <= 8'h00;
      vdg_late  <= 1'b0;
      cpu_rdata <= 8'h00;
      cpu_ack   <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_din   <= 8'h00;
      an_g      <= 1'b0;
      gm        <= 3'b000;
      css       <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      pend_addr <= pend_addr_n;
      vdg_dd    <= vdg_dd_n;
      vdg_late  <= vdg_late_n;
      cpu_rdata <= cpu_rdata_n;
      cpu_ack   <= cpu_ack_n;
      ram_addr  <= ram_addr_n;
      ram_we    <= ram_we_n;
      ram_din   <= ram_din_n;
      an_g      <= an_g_n;
      gm        <= gm_n;
      css       <= css_n;
    end
  end

endmodule

// File: tb/tb_mc10_vram_arbiter.sv
// Directed bench for mc10_vram_arbiter with a behavioural 8K x 8 synchronous BRAM.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// Expected values are hand-derived cycle counts and data constants.
module tb_mc10_vram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        vdg_req = 1'b0;
  logic [12:0] vdg_addr = '0;
  logic [7:0]  vdg_dd;
  logic        vdg_late;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = '0;
  logic        an_g;
  logic [2:0]  gm;
  logic        css;

  logic [7:0]  mem [0:8191];
  int          n_chk = 0;
  int          n_fail = 0;

  mc10_vram_arbiter dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .vdg_req  (vdg_req),
    .vdg_addr (vdg_addr),
    .vdg_dd   (vdg_dd),
    .vdg_late (vdg_late),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .an_g     (an_g),
    .gm       (gm),
    .css      (css)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous single-port BRAM, read-before-write
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0123] = 8'h5A;
    mem[13'h0200] = 8'h11;
    mem[13'h0300] = 8'h33;
    mem[13'h0400] = 8'h44;

    // Reset state
    repeat (3) tick();
    chk("rst_vdg_dd", {8'h0, vdg_dd}, 16'h0);
    chk("rst_ack", {15'h0, cpu_ack}, 16'h0);
    chk("rst_ram_we", {15'h0, ram_we}, 16'h0);
    chk("rst_ram_addr", {3'h0, ram_addr}, 16'h0);
    chk("rst_latch", {11'h0, css, an_g, gm}, 16'h0);
    reset_n = 1'b1;
    tick();

    // VDG fetch from idle: data 3 clocks after the strobe
    vdg_req = 1'b1; vdg_addr = 13'h0123;
    tick();
    vdg_req = 1'b0;
    chk("vdg_ram_addr", {3'h0, ram_addr}, 16'h0123);
    tick();
    chk("vdg_dd_early", {8'h0, vdg_dd}, 16'h0000);
    tick();
    chk("vdg_dd_+3", {8'h0, vdg_dd}, 16'h005A);
    tick(); tick();
    chk("vdg_dd_held", {8'h0, vdg_dd}, 16'h005A);

    // CPU write 0x4010 <- 0xC3: ack at +2, one-cycle ram_we at offset 0x010
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4010; cpu_wdata = 8'hC3;
    tick();
    chk("wr_ram_we", {15'h0, ram_we}, 16'h1);
    chk("wr_ram_addr", {3'h0, ram_addr}, 16'h0010);
    chk("wr_ram_din", {8'h0, ram_din}, 16'h00C3);
    chk("wr_ack_+1", {15'h0, cpu_ack}, 16'h0);
    tick();
    chk("wr_ack_+2", {15'h0, cpu_ack}, 16'h1);
    chk("wr_we_drop", {15'h0, ram_we}, 16'h0);
    tick();
    cpu_req = 1'b0;
    chk("wr_no_restart", {14'h0, ram_we, cpu_ack}, 16'h0);
    chk("wr_mem", {8'h0, mem[13'h0010]}, 16'h00C3);
    tick();

    // CPU read 0x4010: ack and data at +3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4010;
    tick();
    chk("rd_ack_+1", {15'h0, cpu_ack}, 16'h0);
    tick();
    chk("rd_ack_+2", {15'h0, cpu_ack}, 16'h0);
    tick();
    chk("rd_ack_+3", {15'h0, cpu_ack}, 16'h1);
    chk("rd_data", {8'h0, cpu_rdata}, 16'h00C3);
    tick();
    cpu_req = 1'b0;
    chk("rd_ack_pulse", {15'h0, cpu_ack}, 16'h0);
    tick();

    // Simultaneous VDG fetch and CPU read: VDG first, CPU ack at +6
    vdg_req = 1'b1; vdg_addr = 13'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4010;
    tick();
    vdg_req = 1'b0;
    tick(); tick();
    chk("sim_vdg_dd", {8'h0, vdg_dd}, 16'h0011);
    chk("sim_ack_+3", {15'h0, cpu_ack}, 16'h0);
    tick(); tick();
    chk("sim_ack_+5", {15'h0, cpu_ack}, 16'h0);
    tick();
    chk("sim_ack_+6", {15'h0, cpu_ack}, 16'h1);
    chk("sim_rdata", {8'h0, cpu_rdata}, 16'h00C3);
    tick();
    cpu_req = 1'b0;
    tick();

    // Control latch write, read-back, unmapped reads
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hBFFF; cpu_wdata = 8'h74;
    tick();
    chk("ctl_wr_ack", {15'h0, cpu_ack}, 16'h1);
    chk("ctl_latch", {11'h0, css, an_g, gm}, 16'h001D);
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hBFFF;
    tick();
    chk("ctl_rd_ack", {15'h0, cpu_ack}, 16'h1);
    chk("ctl_rd_data", {8'h0, cpu_rdata}, 16'h0074);
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    tick();
    chk("unm_ack", {15'h0, cpu_ack}, 16'h1);
    chk("unm_data", {8'h0, cpu_rdata}, 16'h00FF);
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h6000;
    tick();
    chk("past_ram_ack", {15'h0, cpu_ack}, 16'h1);
    chk("past_ram_data", {8'h0, cpu_rdata}, 16'h00FF);
    tick();
    cpu_req = 1'b0;
    tick();

    // Overrun: two fetches back to back while the CPU write sits in CWR
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4020; cpu_wdata = 8'h99;
    tick();
    vdg_req = 1'b1; vdg_addr = 13'h0300;
    tick();
    vdg_addr = 13'h0400;
    chk("ovr_no_late_yet", {15'h0, vdg_late}, 16'h0);
    tick();
    vdg_req = 1'b0; cpu_req = 1'b0;
    chk("ovr_late", {15'h0, vdg_late}, 16'h1);
    chk("ovr_addr", {3'h0, ram_addr}, 16'h0400);
    tick();
    chk("ovr_late_pulse", {15'h0, vdg_late}, 16'h0);
    tick();
    chk("ovr_vdg_dd", {8'h0, vdg_dd}, 16'h0044);
    repeat (5) tick();
    chk("ovr_single_fetch", {3'h0, ram_addr}, 16'h0400);
    chk("ovr_dd_held", {8'h0, vdg_dd}, 16'h0044);
    chk("ovr_wr_mem", {8'h0, mem[13'h0020]}, 16'h0099);

    // Reset in the middle of a RAM write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4030; cpu_wdata = 8'h55;
    tick();
    chk("mid_we_before", {15'h0, ram_we}, 16'h1);
    reset_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("mid_we_drop", {15'h0, ram_we}, 16'h0);
    chk("mid_outputs", {vdg_dd, 1'b0, vdg_late, cpu_ack, css, an_g, gm}, 16'h0);
    chk("mid_rdata", {8'h0, cpu_rdata}, 16'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_ack", {15'h0, cpu_ack}, 16'h0);
    end
    chk("mid_no_write", {8'h0, mem[13'h0030]}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc10_vram_arbiter.md
Name: mc10_vram_arbiter

Overview:
- Memory-side responder for the MC6847 fetch interface: serves the VDG's 13-bit `videoaddr` fetches from the shared single-port video/system RAM.
- Arbitrates those fetches against CPU RAM accesses and returns fetched bytes on a held data bus, which the VDG wrapper registers as `dd`.
- Implements the MC10 VDG control latch at CTRL_ADDR, which drives `an_g`, `gm` and `css`.
- Sits between the CPU bus decode, the synchronous BRAM and the `mc6847_mc10` instance.

Parameters:
- RAM_BASE, 16'h4000, CPU address of RAM byte 0.
- RAM_AW, 13, RAM address width; RAM spans RAM_BASE to RAM_BASE+2^RAM_AW-1.
- CTRL_ADDR, 16'hBFFF, CPU address of the VDG control latch.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vdg_req  in  1  one-cycle fetch strobe, aligned to the VDG clk_ena.
- vdg_addr  in  13  VDG fetch address, valid with vdg_req.
- vdg_dd  out  8  fetched byte, held until the next fetch completes.
- vdg_late  out  1  one-cycle pulse: a pending fetch was overwritten.
- cpu_req  in  1  CPU access request, level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data, valid in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_addr  out  RAM_AW  BRAM address (registered).
- ram_we  out  1  BRAM write enable (registered).
- ram_din  out  8  BRAM write data (registered).
- ram_dout  in  8  BRAM read data, valid one clock after ram_addr.
- an_g  out  1  control latch bit 5.
- gm  out  3  control latch bits 4:2.
- css  out  1  control latch bit 6.

Behaviour:
- **Reset.** reset_n low clears all of the following, asynchronously: vdg_dd=0, vdg_late=0, cpu_rdata=0, cpu_ack=0, ram_addr=0, ram_we=0, ram_din=0, an_g=0, gm=0, css=0, pending flag=0, state=IDLE.
- **Reset mid-operation.** Reset mid-access aborts the access: no ack and no further RAM write.
- **Pending register.** vdg_req sets pend=1 and captures vdg_addr. If pend is already 1 and not yet issued, the new address overwrites it and vdg_late pulses.
- **States.** IDLE, VADDR, VCAP, CADDR, CCAP, CWR.
- **IDLE arbitration (VDG wins).**
  - If pend=1 or vdg_req: ram_addr<=fetch address, clear pend, go to VADDR. A vdg_req in that same cycle is used directly.
  - Else if cpu_req and the address is in RAM: ram_addr<=cpu_addr-RAM_BASE (low RAM_AW bits).
    - Write: ram_we<=1, ram_din<=cpu_wdata, go to CWR.
    - Read: go to CADDR.
  - Else if cpu_req and cpu_addr==CTRL_ADDR:
    - Write: {css,an_g,gm}<={wdata[6],wdata[5],wdata[4:2]}.
    - Read: cpu_rdata<={1'b0,css,an_g,gm,2'b00}.
    - cpu_ack pulses next cycle; stay in IDLE.
  - Else if cpu_req (unmapped): cpu_rdata<=8'hFF, cpu_ack pulses next cycle, no side effects.
- **VDG path.** VADDR waits for BRAM → VCAP: vdg_dd<=ram_dout → IDLE.
- **CPU read path.** CADDR → CCAP: cpu_rdata<=ram_dout, cpu_ack<=1 → IDLE.
- **CPU write path.** CWR: ram_we<=0, cpu_ack<=1 → IDLE.
- **Latency from an idle arbiter.**
  - VDG: vdg_dd valid 3 clocks after vdg_req.
  - CPU RAM read: ack 3 clocks after cpu_req. RAM write: ack 2 clocks. Control or unmapped: ack 1 clock.
  - Worst-case CPU stall is 3 extra clocks per competing VDG fetch.
- **Handshake.**
  - The CPU deasserts cpu_req in the cycle after cpu_ack. If it is still high in IDLE after the ack, it is a new access.
  - No CPU access ever starts while pend=1.
- **Collisions.**
  - A vdg_req arriving during a CPU sequence is held in pend and issued at the next IDLE, never dropped silently.
  - Two vdg_req with no IDLE cycle between them: the second wins and vdg_late pulses.
- **RAM addressing.** The RAM offset wraps modulo 2^RAM_AW. vdg_addr wider than RAM_AW uses its low RAM_AW bits.
- **Control latch.** The latch affects the VDG mode from the cycle after the write.

Test Plan:
- **Reset.** Assert reset_n=0 mid-CWR → ram_we drops immediately; all outputs 0; no ack after release.
- **VDG fetch.** Preload RAM[0x0123]=0x5A; pulse vdg_req, vdg_addr=0x0123 → vdg_dd=0x5A 3 clocks later; held until next fetch.
- **CPU write/read.** CPU write 0x4010←0xC3 → ack at +2, ram_we one cycle at offset 0x010. CPU read 0x4010 → cpu_rdata=0xC3 with ack at +3.
- **Simultaneous requests.** cpu_req read and vdg_req in the same cycle → VDG served first (vdg_dd at +3); CPU ack at +6.
- **Control latch.** Write 0xBFFF←0x74 → css=1, an_g=1, gm=3'b101 next cycle; read 0xBFFF returns 0x74; read 0x2000 returns 0xFF with ack at +1.
- **Overrun.** Two vdg_req on consecutive cycles while a CPU write is in CWR → vdg_late pulses once; only the second address is fetched.
